e203_exu_alu_share_arb: RTL and testbench

Arbiter and sequencer that shares the single shared ALU datapath (adder/shifter/logic unit driven by one-hot op bits plus op1/op2) between two requesters. Requester 0 is the regular single-cycle ALU issue path. Requester 1 is an iterative multi-cycle unit that needs back-to-back datapath cycles. The block sits in the EXU between both requesters and the datapath. It provides fixed priority with a starvation guard, a lock mode for uninterrupted sequences, and a lock timeout.

---
 rtl/e203_exu_alu_share_arb_if.sv | 49 ++++
 rtl/e203_exu_alu_share_arb.sv | 161 ++++++++++++++++
 tb/tb_e203_exu_alu_share_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/e203_exu_alu_share_arb_if.sv
// Bundle of both requester handshakes and the shared ALU datapath port.
// The master modport is the arbiter side; the slave modport is the requesters/datapath side.
interface e203_exu_alu_share_arb_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 11
);
  logic            r0_req;
  logic            r0_gnt;
  logic [OP_W-1:0] r0_op;
  logic [XLEN-1:0] r0_op1;
  logic [XLEN-1:0] r0_op2;
  logic [XLEN-1:0] r0_res;

  logic            r1_req;
  logic            r1_lock;
  logic            r1_gnt;
  logic [OP_W-1:0] r1_op;
  logic [XLEN-1:0] r1_op1;
  logic [XLEN-1:0] r1_op2;
  logic [XLEN-1:0] r1_res_q;
  logic            r1_res_vld;

  logic            lock_err;

  logic [OP_W-1:0] dp_op;
  logic [XLEN-1:0] dp_op1;
  logic [XLEN-1:0] dp_op2;
  logic [XLEN-1:0] dp_res;

  modport master (
    input  r0_req, r0_op, r0_op1, r0_op2,
    input  r1_req, r1_lock, r1_op, r1_op1, r1_op2,
    input  dp_res,
    output r0_gnt, r0_res,
    output r1_gnt, r1_res_q, r1_res_vld,
    output lock_err,
    output dp_op, dp_op1, dp_op2
  );

  modport slave (
    output r0_req, r0_op, r0_op1, r0_op2,
    output r1_req, r1_lock, r1_op, r1_op1, r1_op2,
    output dp_res,
    input  r0_gnt, r0_res,
    input  r1_gnt, r1_res_q, r1_res_vld,
    input  lock_err,
    input  dp_op, dp_op1, dp_op2
  );
endinterface

// File: rtl/e203_exu_alu_share_arb.sv
// Shares one ALU datapath between the single-cycle issue path (r0) and the iterative unit (r1):
// fixed r0 priority, r1 starvation override, r1 lock mode with a timeout release.
module e203_exu_alu_share_arb #(
  parameter int XLEN       = 32,
  parameter int OP_W       = 11,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  e203_exu_alu_share_arb_if.master  bus
);

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_LOCK      = 2'b01;
  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
  localparam logic [7:0] LOCK_MAX_C   = 8'(LOCK_MAX);

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [3:0]      starve_cnt_r;
  logic [7:0]      lock_cnt_r;
  logic [7:0]      lock_cnt_nxt_s;
  logic            lock_err_r;
  logic            lock_err_nxt_s;
  logic [XLEN-1:0] r1_res_q_r;
  logic            r1_res_vld_r;
  logic            r0_gnt_s;
  logic            r1_gnt_s;
  logic [OP_W-1:0] dp_op_s;
  logic [XLEN-1:0] dp_op1_s;
  logic [XLEN-1:0] dp_op2_s;

  // Grant decode: zero-latency from requests and registered state.
  always_comb begin
    r0_gnt_s = 1'b0;
    r1_gnt_s = 1'b0;
    if (rst) begin
      r0_gnt_s = 1'b0;
      r1_gnt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.r1_req && (starve_cnt_r == STARVE_MAX_C)) begin
            r1_gnt_s = 1'b1;
          end else if (bus.r0_req) begin
            r0_gnt_s = 1'b1;
          end else if (bus.r1_req) begin
            r1_gnt_s = 1'b1;
          end else begin
            r0_gnt_s = 1'b0;
            r1_gnt_s = 1'b0;
          end
        end
        ST_LOCK: begin
          r1_gnt_s = bus.r1_req;
        end
        default: begin
          r0_gnt_s = 1'b0;
          r1_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath mux; with no grant every op bit is low so the datapath idles.
  always_comb begin
    dp_op_s  = {OP_W{1'b0}};
    dp_op1_s = {XLEN{1'b0}};
    dp_op2_s = {XLEN{1'b0}};
    if (r0_gnt_s) begin
      dp_op_s  = bus.r0_op;
      dp_op1_s = bus.r0_op1;
      dp_op2_s = bus.r0_op2;
    end else if (r1_gnt_s) begin
      dp_op_s  = bus.r1_op;
      dp_op1_s = bus.r1_op1;
      dp_op2_s = bus.r1_op2;
    end else begin
      dp_op_s  = {OP_W{1'b0}};
      dp_op1_s = {XLEN{1'b0}};
      dp_op2_s = {XLEN{1'b0}};
    end
  end

  // Lock sequencing; the timeout check wins over a continuing locked grant.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    lock_err_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (r1_gnt_s && bus.r1_lock) begin
          state_nxt_s    = ST_LOCK;
          lock_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = lock_cnt_r;
        end
      end
      ST_LOCK: begin
        if (lock_cnt_r == LOCK_MAX_C) begin
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
          lock_err_nxt_s = 1'b1;
        end else if ((r1_gnt_s && !bus.r1_lock) || !bus.r1_req) begin
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = ST_LOCK;
          lock_cnt_nxt_s = lock_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        lock_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State, counters and the registered r1 result path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= 4'd0;
      lock_cnt_r   <= 8'd0;
      lock_err_r   <= 1'b0;
      r1_res_q_r   <= {XLEN{1'b0}};
      r1_res_vld_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      lock_err_r <= lock_err_nxt_s;
      if (!bus.r1_req || r1_gnt_s) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != STARVE_MAX_C) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
      if (r1_gnt_s) begin
        r1_res_q_r   <= bus.dp_res;
        r1_res_vld_r <= 1'b1;
      end else begin
        r1_res_q_r   <= r1_res_q_r;
        r1_res_vld_r <= 1'b0;
      end
    end
  end

  assign bus.r0_gnt     = r0_gnt_s;
  assign bus.r1_gnt     = r1_gnt_s;
  assign bus.r0_res     = bus.dp_res;
  assign bus.r1_res_q   = r1_res_q_r;
  assign bus.r1_res_vld = r1_res_vld_r;
  assign bus.lock_err   = lock_err_r;
  assign bus.dp_op      = dp_op_s;
  assign bus.dp_op1     = dp_op1_s;
  assign bus.dp_op2     = dp_op2_s;

endmodule

// File: tb/tb_e203_exu_alu_share_arb.sv
// Randomized and directed bench for e203_exu_alu_share_arb, checked every cycle against
// a behavioural arbitration model and a behavioural ALU that also drives dp_res.
module tb_e203_exu_alu_share_arb;
  localparam int XLEN = 32;
  localparam int OP_W = 11;
  localparam int SM   = 4;
  localparam int LM   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_exu_alu_share_arb_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

  e203_exu_alu_share_arb #(
    .XLEN(XLEN), .OP_W(OP_W), .STARVE_MAX(SM), .LOCK_MAX(LM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // op bits: add sub xor sll srl sra or and slt sltu lui
  function automatic logic [31:0] alu_f(logic [10:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    if (op[0])  r = a + b;
    if (op[1])  r = a - b;
    if (op[2])  r = a ^ b;
    if (op[3])  r = a << b[4:0];
    if (op[4])  r = a >> b[4:0];
    if (op[5])  r = 32'($signed(a) >>> b[4:0]);
    if (op[6])  r = a | b;
    if (op[7])  r = a & b;
    if (op[8])  r = {31'd0, $signed(a) < $signed(b)};
    if (op[9])  r = {31'd0, a < b};
    if (op[10]) r = b;
    return r;
  endfunction

  assign bus.dp_res = alu_f(bus.dp_op, bus.dp_op1, bus.dp_op2);

  function automatic logic [10:0] rand_op();
    logic [10:0] one;
    one = 11'd1;
    return one << $urandom_range(0, 10);
  endfunction

  int n_chk = 0;
  int n_pass = 0;
  // reference model: locked flag, sequence age, consecutive denied r1 cycles
  bit          m_lock = 1'b0;
  int          m_age = 0;
  int          m_starve = 0;
  logic [31:0] m_q = 32'd0;
  bit          m_vld = 1'b0;
  bit          m_err = 1'b0;
  bit          e_g0, e_g1;
  bit          r0_pend = 1'b0;
  bit          r1_pend = 1'b0;
  int          err_seen = 0;
  int          r1_gnt_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc(input bit r, input bit q0, input bit q1, input bit l1);
    logic [10:0] x_op;
    logic [31:0] x_a, x_b;
    rst = r;
    bus.r0_req = q0;
    bus.r1_req = q1;
    bus.r1_lock = l1;
    if (!r0_pend) begin
      bus.r0_op = rand_op(); bus.r0_op1 = $urandom; bus.r0_op2 = $urandom;
    end
    if (!r1_pend) begin
      bus.r1_op = rand_op(); bus.r1_op1 = $urandom; bus.r1_op2 = $urandom;
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!r) begin
      if (m_lock) e_g1 = q1;
      else if (q1 && m_starve >= SM) e_g1 = 1'b1;
      else if (q0) e_g0 = 1'b1;
      else if (q1) e_g1 = 1'b1;
    end
    x_op = 11'd0; x_a = 32'd0; x_b = 32'd0;
    if (e_g0) begin x_op = bus.r0_op; x_a = bus.r0_op1; x_b = bus.r0_op2; end
    if (e_g1) begin x_op = bus.r1_op; x_a = bus.r1_op1; x_b = bus.r1_op2; end
    @(negedge clk);
    chk("r0_gnt", 32'(bus.r0_gnt), 32'(e_g0));
    chk("r1_gnt", 32'(bus.r1_gnt), 32'(e_g1));
    chk("dp_op", 32'(bus.dp_op), 32'(x_op));
    chk("dp_op1", bus.dp_op1, x_a);
    chk("dp_op2", bus.dp_op2, x_b);
    if (e_g0) chk("r0_res", bus.r0_res, alu_f(bus.r0_op, bus.r0_op1, bus.r0_op2));
    chk("r1_res_q", bus.r1_res_q, m_q);
    chk("r1_res_vld", 32'(bus.r1_res_vld), 32'(m_vld));
    chk("lock_err", 32'(bus.lock_err), 32'(m_err));
    if (bus.lock_err) err_seen++;
    if (bus.r1_gnt) r1_gnt_seen++;
    @(posedge clk);
    if (r) begin
      m_lock = 1'b0; m_age = 0; m_starve = 0; m_q = 32'd0; m_vld = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      m_vld = e_g1;
      if (e_g1) m_q = alu_f(bus.r1_op, bus.r1_op1, bus.r1_op2);
      if (!q1 || e_g1) m_starve = 0;
      else if (m_starve < SM) m_starve++;
      if (!m_lock) begin
        if (e_g1 && l1) begin m_lock = 1'b1; m_age = 1; end
      end else if (m_age == LM) begin
        m_lock = 1'b0; m_err = 1'b1;
      end else if ((e_g1 && !l1) || !q1) begin
        m_lock = 1'b0;
      end else begin
        m_age++;
      end
    end
    r0_pend = q0 && !e_g0 && !r;
    r1_pend = q1 && !e_g1 && !r;
    #1;
  endtask

  initial begin
    int base;
    bit q0, q1;
    rst = 1'b1;
    bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.r1_lock = 1'b0;
    bus.r0_op = 11'd0; bus.r0_op1 = 32'd0; bus.r0_op2 = 32'd0;
    bus.r1_op = 11'd0; bus.r1_op1 = 32'd0; bus.r1_op2 = 32'd0;
    @(posedge clk);
    #1;
    // reset with both requests high
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    // simple priority: r0 add 5+3 first, r1 via starvation override in cycle 5
    bus.r0_op = 11'd1; bus.r0_op1 = 32'd5; bus.r0_op2 = 32'd3;
    r0_pend = 1'b1;
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    // locked sequence of three ops
    base = r1_gnt_seen;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("locked_seq_grants", 32'(r1_gnt_seen - base), 32'd3);
    // abandon inside LOCK
    base = err_seen;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abandon_no_err", 32'(err_seen - base), 32'd0);
    // lock timeout under continuous r0 traffic
    base = err_seen;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("timeout_err_pulses", 32'(err_seen - base), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // reset asserted mid-lock
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // randomized traffic, requests held until granted
    for (int i = 0; i < 600; i++) begin
      q0 = r0_pend || ($urandom_range(0, 99) < 60);
      q1 = r1_pend || (m_lock ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 45));
      cyc(($urandom_range(0, 199) == 0), q0, q1, ($urandom_range(0, 99) < 80));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
